// File: rtl/reg_xfer_sequencer.sv
// reg_xfer_sequencer: moves a register or immediate value over the shared
// internal bus into a destination register with a two-phase DRIVE/LOAD
// sequence, fed from a 2-entry command FIFO.
// Optional N/Z flag outputs are built when XFER_FLAGS_EN is defined.
module reg_xfer_sequencer #(
   parameter int N_REGS = 4,
   parameter int WIDTH  = 8,
   localparam int IW    = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [IW-1:0]           cmd_src,
   input  logic [IW-1:0]           cmd_dst,
   input  logic                    cmd_imm_en,
   input  logic [WIDTH-1:0]        cmd_imm,
   input  logic [N_REGS*WIDTH-1:0] reg_q,
   output logic [N_REGS-1:0]       reg_oe,
   output logic [N_REGS-1:0]       reg_load,
   output logic [WIDTH-1:0]        bus_out,
   output logic                    busy,
   output logic                    done
`ifdef XFER_FLAGS_EN
   ,
   input  logic                    cmd_flags_en,
   output logic                    flag_we,
   output logic                    flag_n,
   output logic                    flag_z
`endif
);

   // Index space padded to a power of two so out-of-range indices read as 0
   localparam int NW = 1 << IW;

   typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, LOAD = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [1:0]       count_q, count_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic             push, pop;

   logic [IW-1:0]    fifo_src_q    [2];
   logic [IW-1:0]    fifo_dst_q    [2];
   logic             fifo_imm_en_q [2];
   logic [WIDTH-1:0] fifo_imm_q    [2];

   logic [IW-1:0]    src_q, src_d;
   logic [IW-1:0]    dst_q, dst_d;
   logic             imm_en_q, imm_en_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [WIDTH-1:0] bus_latch_q, bus_latch_d;
   logic [WIDTH-1:0] reg_word [NW];

`ifdef XFER_FLAGS_EN
   logic             fifo_flags_q [2];
   logic             flags_en_q, flags_en_d;
`endif

   // Unpack the register bank and decode the one-hot strobes from registered state
   for (genvar gi = 0; gi < NW; gi++) begin : g_word
      if (gi < N_REGS) begin : g_real
         assign reg_word[gi] = reg_q[gi*WIDTH +: WIDTH];
         assign reg_oe[gi]   = (state_q == DRIVE) && !imm_en_q && (src_q == IW'(gi));
         assign reg_load[gi] = (state_q == LOAD) && (dst_q == IW'(gi));
      end else begin : g_pad
         assign reg_word[gi] = '0;
      end
   end

   // Buffer can take a command whenever it is not full; no pass-through
   assign cmd_ready = (count_q != 2'd2);
   assign push      = cmd_valid && cmd_ready;
   assign busy      = (state_q != IDLE) || (count_q != 2'd0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and FIFO pop: IDLE and LOAD both pick up the next command
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != 2'd0) begin
               pop     = 1'b1;
               state_d = DRIVE;
            end
         end
         DRIVE: state_d = LOAD;
         LOAD: begin
            if (count_q != 2'd0) begin
               pop     = 1'b1;
               state_d = DRIVE;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus value, done pulse and flag outputs from registered state
   always_comb begin
      bus_out = bus_latch_q;
      done    = 1'b0;
`ifdef XFER_FLAGS_EN
      flag_we = 1'b0;
      flag_n  = 1'b0;
      flag_z  = 1'b0;
`endif
      if (state_q == DRIVE) begin
         bus_out = imm_en_q ? imm_q : reg_word[src_q];
      end else if (state_q == LOAD) begin
         done    = 1'b1;
`ifdef XFER_FLAGS_EN
         flag_we = flags_en_q;
         flag_n  = bus_latch_q[WIDTH-1];
         flag_z  = (bus_latch_q == '0);
`endif
      end
   end

   // Pointer/count update and command-register load on pop
   always_comb begin
      wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d    = pop  ? ~rd_ptr_q : rd_ptr_q;
      count_d     = count_q;
      if (push && !pop)      count_d = count_q + 2'd1;
      else if (pop && !push) count_d = count_q - 2'd1;
      src_d       = pop ? fifo_src_q[rd_ptr_q]    : src_q;
      dst_d       = pop ? fifo_dst_q[rd_ptr_q]    : dst_q;
      imm_en_d    = pop ? fifo_imm_en_q[rd_ptr_q] : imm_en_q;
      imm_d       = pop ? fifo_imm_q[rd_ptr_q]    : imm_q;
      bus_latch_d = (state_q == DRIVE) ? bus_out : bus_latch_q;
`ifdef XFER_FLAGS_EN
      flags_en_d  = pop ? fifo_flags_q[rd_ptr_q] : flags_en_q;
`endif
   end

   // FIFO storage, pointers, command register and bus latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_src_q[i]    <= '0;
            fifo_dst_q[i]    <= '0;
            fifo_imm_en_q[i] <= 1'b0;
            fifo_imm_q[i]    <= '0;
`ifdef XFER_FLAGS_EN
            fifo_flags_q[i]  <= 1'b0;
`endif
         end
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         src_q       <= '0;
         dst_q       <= '0;
         imm_en_q    <= 1'b0;
         imm_q       <= '0;
         bus_latch_q <= '0;
`ifdef XFER_FLAGS_EN
         flags_en_q  <= 1'b0;
`endif
      end else begin
         if (push) begin
            fifo_src_q[wr_ptr_q]    <= cmd_src;
            fifo_dst_q[wr_ptr_q]    <= cmd_dst;
            fifo_imm_en_q[wr_ptr_q] <= cmd_imm_en;
            fifo_imm_q[wr_ptr_q]    <= cmd_imm;
`ifdef XFER_FLAGS_EN
            fifo_flags_q[wr_ptr_q]  <= cmd_flags_en;
`endif
         end
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         imm_en_q    <= imm_en_d;
         imm_q       <= imm_d;
         bus_latch_q <= bus_latch_d;
`ifdef XFER_FLAGS_EN
         flags_en_q  <= flags_en_d;
`endif
      end
   end

endmodule
